imem_loader: RTL and testbench

Boot-time writer for the instruction memory. It takes a byte stream from a serial or debug front end, assembles little-endian 32-bit instruction words and writes them into consecutive IMEM word addresses starting at 0. It holds the core in reset while loading. It sits between the byte-stream source and the IMEM write port, as the producer side of the memory that the fetch path reads by `PC[19:2]`.

---
 rtl/imem_loader.sv | 126 ++++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Boot-time IMEM loader: collects a little-endian word count and instruction words
// from a byte stream, writes them to consecutive IMEM addresses and holds the core meanwhile.
module imem_loader #(
  parameter int INST_WIDTH_LENGTH = 32,
  parameter int ADDR_WIDTH        = 18,
  parameter int MEM_DEPTH         = 1 << 18
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic                         rx_ready,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_waddr,
  output logic [INST_WIDTH_LENGTH-1:0] mem_wdata,
  output logic                         busy,
  output logic                         cpu_hold,
  output logic                         done,
  output logic                         err
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t                       state_q, state_d;
  logic [1:0]                   byteCnt_q, byteCnt_d;
  logic [CNT_W-1:0]             wordCnt_q, wordCnt_d;
  logic [31:0]                  len_q, len_d;
  logic [INST_WIDTH_LENGTH-1:0] word_q, word_d;

  logic                         accept;
  logic [31:0]                  lenNext;
  logic [CNT_W-1:0]             wordCntInc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      byteCnt_q <= '0;
      wordCnt_q <= '0;
      len_q     <= '0;
      word_q    <= '0;
    end else begin
      state_q   <= state_d;
      byteCnt_q <= byteCnt_d;
      wordCnt_q <= wordCnt_d;
      len_q     <= len_d;
      word_q    <= word_d;
    end
  end

  // Bytes shift in from the top so the first byte received ends up in bits [7:0].
  assign lenNext    = {rx_data, len_q[31:8]};
  assign wordCntInc = wordCnt_q + 1'b1;
  assign accept     = rx_valid && rx_ready;

  always_comb begin
    state_d   = state_q;
    byteCnt_d = byteCnt_q;
    wordCnt_d = wordCnt_q;
    len_d     = len_q;
    word_d    = word_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          byteCnt_d = '0;
          wordCnt_d = '0;
          len_d     = '0;
          state_d   = LEN;
        end
      end
      LEN: begin
        if (accept) begin
          len_d     = lenNext;
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) begin
            if (lenNext == 32'd0) begin
              state_d = DONE;
            end else if (lenNext > 32'(MEM_DEPTH)) begin
              state_d = ERR;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      DATA: begin
        if (accept) begin
          word_d    = {rx_data, word_q[INST_WIDTH_LENGTH-1:8]};
          byteCnt_d = byteCnt_q + 2'd1;
          if (byteCnt_q == 2'd3) begin
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        wordCnt_d = wordCntInc;
        if (32'(wordCntInc) == len_q) begin
          state_d = DONE;
        end else begin
          state_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write strobe is masked by reset so an abort during WRITE never reaches the memory.
  assign rx_ready  = (state_q == LEN) || (state_q == DATA);
  assign mem_we    = (state_q == WRITE) && !rst;
  assign mem_waddr = wordCnt_q[ADDR_WIDTH-1:0];
  assign mem_wdata = word_q;
  assign busy      = (state_q == LEN) || (state_q == DATA) || (state_q == WRITE);
  assign cpu_hold  = busy;
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: reset, continuous and stalled loads,
// zero/oversize/max lengths and reset in the middle of a word.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [17:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;
  int edgeCnt = 0;
  int holdCnt = 0;

  logic [17:0] wAddr[$];
  logic [31:0] wData[$];
  int          wEdge[$];

  logic [7:0] twoWord  [12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                8'h93, 8'h00, 8'h10, 8'h00};
  logic [7:0] zeroLen  [12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] overLen  [12] = '{8'h01, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] oneWord  [12] = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                                8'h00, 8'h00, 8'h00, 8'h00};
  logic [7:0] maxLenMid[12] = '{8'h00, 8'h00, 8'h04, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'h00, 8'h00};

  imem_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_we   (mem_we),
    .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata),
    .busy     (busy),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Edge counter plus a log of every write strobe seen at a rising edge.
  always @(posedge clk) begin
    edgeCnt <= edgeCnt + 1;
    if (cpu_hold === 1'b1) holdCnt <= holdCnt + 1;
    if (mem_we === 1'b1) begin
      wAddr.push_back(mem_waddr);
      wData.push_back(mem_wdata);
      wEdge.push_back(edgeCnt + 1);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offers one byte, optionally after an idle gap, and returns once it has been taken.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waitCnt;
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      tick();
    end
    rx_valid = 1'b1;
    rx_data  = b;
    waitCnt  = 0;
    while (rx_ready !== 1'b1 && waitCnt < 50) begin
      tick();
      waitCnt++;
    end
    if (waitCnt >= 50) checkOutput("rx_ready_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic sendStream(input logic [7:0] s[12], input int n, input int maxGap);
    for (int i = 0; i < n; i++) begin
      applyStimulus(s[i], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
    end
    rx_valid = 1'b0;
  endtask

  task automatic checkTwoWrites(input string tag, input int base);
    checkOutput({tag, "_wcount"}, 32'(wAddr.size() - base), 32'd2);
    if (wAddr.size() >= base + 2) begin
      checkOutput({tag, "_addr0"}, 32'(wAddr[base]), 32'd0);
      checkOutput({tag, "_data0"}, wData[base], 32'h0000_0013);
      checkOutput({tag, "_addr1"}, 32'(wAddr[base+1]), 32'd1);
      checkOutput({tag, "_data1"}, wData[base+1], 32'h0010_0093);
    end
  endtask

  task automatic runTwoWord(input string tag);
    int base;
    int e0;
    int h0;
    base = wAddr.size();
    h0   = holdCnt;
    pulseStart();
    e0 = edgeCnt;
    checkOutput({tag, "_hold_e0"}, 32'(cpu_hold), 32'd1);
    checkOutput({tag, "_done_e0"}, 32'(done), 32'd0);
    sendStream(twoWord, 12, 0);
    checkOutput({tag, "_done_e13"}, 32'(done), 32'd0);
    tick();
    checkOutput({tag, "_edge_e14"}, 32'(edgeCnt - e0), 32'd14);
    checkOutput({tag, "_done_e14"}, 32'(done), 32'd1);
    checkOutput({tag, "_hold_cycles"}, 32'(holdCnt - h0), 32'd14);
    checkOutput({tag, "_hold_off"}, 32'(cpu_hold), 32'd0);
    checkTwoWrites(tag, base);
    if (wEdge.size() >= base + 2) begin
      checkOutput({tag, "_wedge0"}, 32'(wEdge[base] - e0), 32'd9);
      checkOutput({tag, "_wedge1"}, 32'(wEdge[base+1] - e0), 32'd14);
    end
  endtask

  initial begin
    int base;
    int waitCnt;
    #200000;
    $display("[TB] FAIL global_timeout: observed running expected finished");
    $fatal(1, "[TB] simulation watchdog expired");
  end

  initial begin
    int base;
    int waitCnt;
    rst      = 1'b1;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #1;
    for (int i = 0; i < 2; i++) begin
      start    = 1'($urandom);
      rx_valid = 1'($urandom);
      rx_data  = 8'($urandom);
      tick();
    end
    checkOutput("rst_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_waddr", 32'(mem_waddr), 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    checkOutput("rst_busy_hold", {30'd0, busy, cpu_hold}, 32'd0);
    checkOutput("rst_done_err", {30'd0, done, err}, 32'd0);
    rst      = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    tick();
    checkOutput("idle_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("idle_no_writes", 32'(wAddr.size()), 32'd0);

    runTwoWord("two_word");

    base = wAddr.size();
    pulseStart();
    checkOutput("stall_done_cleared", 32'(done), 32'd0);
    sendStream(twoWord, 12, 5);
    waitCnt = 0;
    while (done !== 1'b1 && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    checkOutput("stall_done", 32'(done), 32'd1);
    checkTwoWrites("stall", base);

    base = wAddr.size();
    pulseStart();
    sendStream(zeroLen, 4, 0);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_err", 32'(err), 32'd0);
    checkOutput("zero_rx_ready", 32'(rx_ready), 32'd0);
    tick();
    checkOutput("zero_no_writes", 32'(wAddr.size() - base), 32'd0);

    base = wAddr.size();
    pulseStart();
    sendStream(overLen, 4, 0);
    checkOutput("over_err", 32'(err), 32'd1);
    checkOutput("over_done", 32'(done), 32'd0);
    checkOutput("over_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("over_no_writes", 32'(wAddr.size() - base), 32'd0);
    pulseStart();
    checkOutput("over_err_cleared", 32'(err), 32'd0);
    checkOutput("over_restart_busy", 32'(busy), 32'd1);
    sendStream(oneWord, 8, 0);
    checkOutput("one_mem_we", 32'(mem_we), 32'd1);
    checkOutput("one_waddr", 32'(mem_waddr), 32'd0);
    checkOutput("one_wdata", mem_wdata, 32'hEFBE_ADDE);
    tick();
    checkOutput("one_done", 32'(done), 32'd1);
    checkOutput("one_wcount", 32'(wAddr.size() - base), 32'd1);

    base = wAddr.size();
    pulseStart();
    sendStream(maxLenMid, 6, 0);
    checkOutput("maxlen_err", 32'(err), 32'd0);
    checkOutput("maxlen_busy", 32'(busy), 32'd1);
    checkOutput("maxlen_rx_ready", 32'(rx_ready), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_mem_we", 32'(mem_we), 32'd0);
    tick();
    checkOutput("midrst_no_writes", 32'(wAddr.size() - base), 32'd0);

    runTwoWord("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
